// File: rtl/dsi_lane_array_if.sv
// Input word stream into the DSI lane array FIFO.
//   in_valid / in_ready : word handshake, a word transfers when both are high
//   in_data             : byte for lane i in in_data[i]
//   in_keep             : lane byte valid (all ones except possibly on the last word)
//   in_last             : final word of a packet
// master = packet source, slave = dsi_lane_array.
interface dsi_lane_array_if #(
  parameter int LANES = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0][7:0] in_data;
  logic [LANES-1:0]      in_keep;
  logic                  in_last;

  modport master (output in_valid, in_data, in_keep, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_keep, in_last, output in_ready);
endinterface

// File: rtl/dsi_lane_array.sv
// Multi-lane DSI data-lane controller. Buffers packets in a FIFO and drives
// LANES lanes in lockstep through LP->HS entry, HS burst and HS->LP exit.
// Optional macro DSI_LANE_ARRAY_STATS_EN adds pkt_count / burst_count outputs.
// Ports:
//   clk_base, reset        : clock, synchronous active-high reset
//   s_in                   : input word stream (dsi_lane_array_if.slave)
//   cfg_t_lpx/prpr/zero/trail/exit : state durations in clk_base cycles (0 acts as 1)
//   hs_data[i]             : parallel byte for lane i, LSB first on the wire
//   hs_en                  : HS driver enable
//   lp_p, lp_n             : LP line levels per lane
//   active                 : state != STOP
//   underflow              : sticky, FIFO ran dry mid-packet
//   pkt_count, burst_count : (stats build only) popped last words / burst starts

// One lane's output register: HS byte, LP levels and the bit used for trail.
module dsi_lane_out (
  input  logic       clk_base,
  input  logic       reset,
  input  logic [2:0] sel,
  input  logic [1:0] lp_nxt,   // {p, n}
  input  logic [7:0] byte_in,
  input  logic       keep,
  output logic [7:0] hs_byte,
  output logic       lp_p,
  output logic       lp_n
);
  localparam logic [2:0] SEL_SYNC  = 3'd2;
  localparam logic [2:0] SEL_DATA  = 3'd3;
  localparam logic [2:0] SEL_TRAIL = 3'd4;

  // Bit 7 of the last byte this lane put on the wire; trail is its inverse.
  logic last_b;

  always_ff @(posedge clk_base) begin
    if (reset) begin
      hs_byte <= 8'h00;
      lp_p    <= 1'b1;
      lp_n    <= 1'b1;
      last_b  <= 1'b0;
    end else begin
      lp_p <= lp_nxt[1];
      lp_n <= lp_nxt[0];
      case (sel)
        SEL_SYNC: begin
          hs_byte <= 8'hB8;
          last_b  <= 1'b1;
        end
        SEL_DATA: begin
          // A lane without a byte in the final word is already trailing.
          if (keep) begin
            hs_byte <= byte_in;
            last_b  <= byte_in[7];
          end else begin
            hs_byte <= {8{~last_b}};
          end
        end
        SEL_TRAIL: hs_byte <= {8{~last_b}};
        default:   hs_byte <= 8'h00;
      endcase
    end
  end
endmodule

module dsi_lane_array #(
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMER_W    = 8,
  parameter int START_LVL  = 4
) (
  input  logic                  clk_base,
  input  logic                  reset,
  dsi_lane_array_if.slave       s_in,
  input  logic [TIMER_W-1:0]    cfg_t_lpx,
  input  logic [TIMER_W-1:0]    cfg_t_prpr,
  input  logic [TIMER_W-1:0]    cfg_t_zero,
  input  logic [TIMER_W-1:0]    cfg_t_trail,
  input  logic [TIMER_W-1:0]    cfg_t_exit,
  output logic [LANES-1:0][7:0] hs_data,
  output logic                  hs_en,
  output logic [LANES-1:0]      lp_p,
  output logic [LANES-1:0]      lp_n,
  output logic                  active,
  output logic                  underflow
`ifdef DSI_LANE_ARRAY_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [15:0]           burst_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] SEL_IDLE  = 3'd0;
  localparam logic [2:0] SEL_ZERO  = 3'd1;
  localparam logic [2:0] SEL_SYNC  = 3'd2;
  localparam logic [2:0] SEL_DATA  = 3'd3;
  localparam logic [2:0] SEL_TRAIL = 3'd4;

  typedef enum logic [2:0] {
    ST_STOP, ST_LPX, ST_PRPR, ST_ZERO, ST_SYNC, ST_TRNSM, ST_TRAIL, ST_EXIT
  } state_t;

  // ---------------- FIFO ----------------
  logic [LANES-1:0][7:0] mem_data [FIFO_DEPTH];
  logic [LANES-1:0]      mem_keep [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic [AW:0]           wptr, rptr, count, last_cnt;
  logic                  full, empty, wr, pop;
  logic [LANES-1:0][7:0] rd_data;
  logic [LANES-1:0]      rd_keep;
  logic                  rd_last;

  assign count         = wptr - rptr;
  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign s_in.in_ready = !reset && !full;
  assign wr            = s_in.in_valid && s_in.in_ready;
  assign rd_data       = mem_data[rptr[AW-1:0]];
  assign rd_keep       = mem_keep[rptr[AW-1:0]];
  assign rd_last       = mem_last[rptr[AW-1:0]];

  always_ff @(posedge clk_base) begin
    if (wr) begin
      mem_data[wptr[AW-1:0]] <= s_in.in_data;
      mem_keep[wptr[AW-1:0]] <= s_in.in_keep;
      mem_last[wptr[AW-1:0]] <= s_in.in_last;
    end
  end

  always_ff @(posedge clk_base) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      last_cnt <= '0;
    end else begin
      if (wr)  wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      // Number of complete packets buffered; a burst may start on any of them.
      case ({wr && s_in.in_last, pop && rd_last})
        2'b10:   last_cnt <= last_cnt + (AW+1)'(1);
        2'b01:   last_cnt <= last_cnt - (AW+1)'(1);
        default: last_cnt <= last_cnt;
      endcase
    end
  end

  // ---------------- FSM ----------------
  state_t             state, nxt;
  logic [TIMER_W-1:0] cnt, dur, entry_dur;
  logic               tdone, uf_set, hs_en_nxt;
  logic [2:0]         lane_sel;
  logic [1:0]         lp_nxt;

  function automatic logic [TIMER_W-1:0] dur_of(input logic [TIMER_W-1:0] c);
    return (c == '0) ? TIMER_W'(1) : c;
  endfunction

  // Duration is captured at entry so config changes mid-state have no effect.
  always_comb begin
    entry_dur = TIMER_W'(1);
    case (nxt)
      ST_LPX:   entry_dur = dur_of(cfg_t_lpx);
      ST_PRPR:  entry_dur = dur_of(cfg_t_prpr);
      ST_ZERO:  entry_dur = dur_of(cfg_t_zero);
      ST_TRAIL: entry_dur = dur_of(cfg_t_trail);
      ST_EXIT:  entry_dur = dur_of(cfg_t_exit);
      default:  entry_dur = TIMER_W'(1);
    endcase
  end

  always_ff @(posedge clk_base) begin
    if (reset) begin
      state <= ST_STOP;
      cnt   <= '0;
      dur   <= TIMER_W'(1);
    end else begin
      state <= nxt;
      if (nxt != state) begin
        cnt <= '0;
        dur <= entry_dur;
      end else if (cnt != '1) begin
        cnt <= cnt + TIMER_W'(1);
      end
    end
  end

  assign tdone  = (cnt == dur - TIMER_W'(1));
  assign active = (state != ST_STOP);

  always_comb begin
    nxt       = state;
    pop       = 1'b0;
    uf_set    = 1'b0;
    lane_sel  = SEL_IDLE;
    lp_nxt    = 2'b11;
    hs_en_nxt = 1'b0;
    case (state)
      ST_STOP: begin
        // cnt==0 only on the first STOP cycle: that cycle is always a hold.
        if (cnt != '0 && (int'(count) >= START_LVL || last_cnt != '0))
          nxt = ST_LPX;
      end
      ST_LPX: begin
        lp_nxt = 2'b01;
        if (tdone) nxt = ST_PRPR;
      end
      ST_PRPR: begin
        lp_nxt = 2'b00;
        if (tdone) nxt = ST_ZERO;
      end
      ST_ZERO: begin
        lp_nxt    = 2'b00;
        hs_en_nxt = 1'b1;
        lane_sel  = SEL_ZERO;
        if (tdone) nxt = ST_SYNC;
      end
      ST_SYNC: begin
        lp_nxt    = 2'b00;
        hs_en_nxt = 1'b1;
        lane_sel  = SEL_SYNC;
        nxt       = ST_TRNSM;
      end
      ST_TRNSM: begin
        lp_nxt    = 2'b00;
        hs_en_nxt = 1'b1;
        if (empty) begin
          // Ran dry: close the burst now; the rest goes out as a new packet.
          uf_set   = 1'b1;
          lane_sel = SEL_TRAIL;
          nxt      = ST_TRAIL;
        end else begin
          pop      = 1'b1;
          lane_sel = SEL_DATA;
          if (rd_last) nxt = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        lp_nxt    = 2'b00;
        hs_en_nxt = 1'b1;
        lane_sel  = SEL_TRAIL;
        if (tdone) nxt = ST_EXIT;
      end
      ST_EXIT: begin
        if (tdone) nxt = ST_STOP;
      end
      default: nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_base) begin
    if (reset) begin
      hs_en     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hs_en <= hs_en_nxt;
      if (uf_set) underflow <= 1'b1;
    end
  end

`ifdef DSI_LANE_ARRAY_STATS_EN
  always_ff @(posedge clk_base) begin
    if (reset) begin
      pkt_count   <= '0;
      burst_count <= '0;
    end else begin
      if (pop && rd_last)                   pkt_count   <= pkt_count + 16'd1;
      if (state == ST_STOP && nxt == ST_LPX) burst_count <= burst_count + 16'd1;
    end
  end
`endif

  // ---------------- lanes ----------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsi_lane_out u_lane (
      .clk_base (clk_base),
      .reset    (reset),
      .sel      (lane_sel),
      .lp_nxt   (lp_nxt),
      .byte_in  (rd_data[i]),
      .keep     (rd_keep[i]),
      .hs_byte  (hs_data[i]),
      .lp_p     (lp_p[i]),
      .lp_n     (lp_n[i])
    );
  end
endmodule
